// File: rtl/rv_pkg.sv
// Shared encodings for the multicycle RV32I control path.
// States, opcodes and datapath select codes used by control, datapath and ALU decoder.
package rv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_BR  = 2'b01;
  localparam logic [1:0] ALU_FN  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4   = 2'b10;

endpackage

// File: rtl/rv_instret_counter.sv
// Retired-instruction counter; wraps modulo 2^CNT_W.
// clr has priority over inc.
module rv_instret_counter
  #(parameter int CNT_W = 32)
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Optional macro RV_ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOP.
module rv_multicycle_ctrl
  import rv_pkg::*;
  #(parameter int CNT_W = 32)
  (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret,
    output logic             illegal_instr
  );

  state_t state, next;
  logic   pc_update, branch;
  logic   ir_w, reg_w, mem_w;
  logic   inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next;
  end

  always_comb begin
    next       = state;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_ADD;
    unique case (state)
      S_FETCH: begin
        alu_src_b  = SRCB_4;
        result_src = RES_ALURES;
        ir_w       = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (1'b1)
          (op == OP_LOAD),
          (op == OP_STORE):  next = S_MEMADR;
          (op == OP_RTYPE):  next = S_EXECR;
          (op == OP_ITYPE):  next = S_EXECI;
          (op == OP_BRANCH): next = S_BEQ;
          (op == OP_JAL):    next = S_JAL;
          default: begin
`ifdef RV_ILLEGAL_TRAP_EN
            next = S_TRAP;
`else
            next = S_FETCH;
`endif
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        next      = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_w      = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_FN;
        next      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_FN;
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w = 1'b1;
        next  = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_BR;
        branch    = 1'b1;
        next      = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_4;
        pc_update = 1'b1;
        next      = S_ALUWB;
      end
      S_TRAP: begin
`ifdef RV_ILLEGAL_TRAP_EN
        next = S_TRAP;
`else
        next = S_FETCH;
`endif
      end
      default: next = S_FETCH;
    endcase
  end

  // Enables are gated by rst_n so nothing can fire while reset is held.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_w;
  assign reg_write = rst_n & reg_w;
  assign mem_write = rst_n & mem_w;
  assign state_o   = state;

  assign inc = (next == S_FETCH) &&
               (state != S_FETCH) &&
               (state != S_TRAP);

  rv_instret_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .clr   (1'b0),
    .cnt   (instret)
  );

`ifdef RV_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_instr <= 1'b0;
    else if (state == S_DECODE && next == S_TRAP)
      illegal_instr <= 1'b1;
  end
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Directed bench for rv_multicycle_ctrl with an instruction-level model.
// Honours RV_ILLEGAL_TRAP_EN for the unknown-opcode scenario.
module tb_rv_multicycle_ctrl;

  localparam int CW = 4;
`ifdef RV_ILLEGAL_TRAP_EN
  localparam int NNOP = 0;
`else
  localparam int NNOP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    op = 7'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0]    state_o;
  logic [CW-1:0] instret;
  logic          illegal_instr;

  rv_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .state_o       (state_o),
    .instret       (instret),
    .illegal_instr (illegal_instr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cnt_m = 0;
  logic ill_m = 1'b0;
  int lat_cyc, mw_cyc, rw_cyc, pcw_cyc;

  typedef struct packed {
    logic       adr, mw, rw, upd, br;
    logic [1:0] rs, a, b, aop;
  } ctl_t;

  // Per-state control word, straight from the state table.
  function automatic ctl_t ctl(input int st);
    ctl_t c;
    case (st)
      0:  c = {5'b00000, 2'd2, 2'd0, 2'd2, 2'd0};
      1:  c = {5'b00000, 2'd0, 2'd1, 2'd1, 2'd0};
      2:  c = {5'b00000, 2'd0, 2'd2, 2'd1, 2'd0};
      3:  c = {5'b10000, 2'd0, 2'd0, 2'd0, 2'd0};
      4:  c = {5'b00100, 2'd1, 2'd0, 2'd0, 2'd0};
      5:  c = {5'b11000, 2'd0, 2'd0, 2'd0, 2'd0};
      6:  c = {5'b00000, 2'd0, 2'd2, 2'd0, 2'd2};
      7:  c = {5'b00000, 2'd0, 2'd2, 2'd1, 2'd2};
      8:  c = {5'b00100, 2'd0, 2'd0, 2'd0, 2'd0};
      9:  c = {5'b00001, 2'd0, 2'd2, 2'd0, 2'd1};
      10: c = {5'b00010, 2'd0, 2'd1, 2'd2, 2'd0};
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int st, input logic [6:0] o,
                      input logic mr, input logic z);
    ctl_t c;
    logic fe;
    @(negedge clk);
    op = o;
    mem_ready = mr;
    zero = z;
    #1;
    c = ctl(st);
    fe = (st == 0) & mr;
    chk("state", 32'(state_o), 32'(st));
    chk("pc_write", 32'(pc_write), 32'(c.upd | fe | (c.br & z)));
    chk("ir_write", 32'(ir_write), 32'(fe));
    chk("adr_src", 32'(adr_src), 32'(c.adr));
    chk("mem_write", 32'(mem_write), 32'(c.mw));
    chk("reg_write", 32'(reg_write), 32'(c.rw));
    chk("result_src", 32'(result_src), 32'(c.rs));
    chk("alu_src_a", 32'(alu_src_a), 32'(c.a));
    chk("alu_src_b", 32'(alu_src_b), 32'(c.b));
    chk("alu_op", 32'(alu_op), 32'(c.aop));
    chk("instret", 32'(instret), 32'(cnt_m));
    chk("illegal", 32'(illegal_instr), 32'(ill_m));
    lat_cyc++;
    if (mem_write) mw_cyc++;
    if (reg_write) rw_cyc++;
    if (pc_write)  pcw_cyc++;
  endtask

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unknown (nop)
  task automatic run(input logic [6:0] o, input int kind,
                     input int fw, input int mwt, input logic z);
    lat_cyc = 0; mw_cyc = 0; rw_cyc = 0; pcw_cyc = 0;
    repeat (fw) step(0, o, 1'b0, z);
    step(0, o, 1'b1, z);
    step(1, o, rnd(), z);
    case (kind)
      0: begin
        step(2, o, rnd(), z);
        repeat (mwt) step(3, o, 1'b0, z);
        step(3, o, 1'b1, z);
        step(4, o, rnd(), z);
      end
      1: begin
        step(2, o, rnd(), z);
        repeat (mwt) step(5, o, 1'b0, z);
        step(5, o, 1'b1, z);
      end
      2: begin step(6, o, rnd(), z); step(8, o, rnd(), z); end
      3: begin step(7, o, rnd(), z); step(8, o, rnd(), z); end
      4: step(9, o, rnd(), z);
      5: begin step(10, o, rnd(), z); step(8, o, rnd(), z); end
      default: ;
    endcase
    cnt_m = (cnt_m + 1) % (1 << CW);
  endtask

  initial begin
    mem_ready = 1'b1;
    zero = 1'b1;
    #2;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_instret", 32'(instret), 32'd0);
    chk("rst_ir_write", 32'(ir_write), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    run(7'b0000011, 0, 0, 0, 1'b0);
    chk("lw_lat", 32'(lat_cyc), 32'd5);
    chk("lw_rw", 32'(rw_cyc), 32'd1);
    step(0, 7'b0000011, 1'b0, 1'b0);
    chk("lw_instret", 32'(instret), 32'd1);

    run(7'b0100011, 1, 0, 3, 1'b0);
    chk("sw_lat", 32'(lat_cyc), 32'd7);
    chk("sw_mw", 32'(mw_cyc), 32'd4);

    run(7'b1100011, 4, 0, 0, 1'b1);
    chk("beq1_lat", 32'(lat_cyc), 32'd3);
    chk("beq1_pcw", 32'(pcw_cyc), 32'd2);
    run(7'b1100011, 4, 0, 0, 1'b0);
    chk("beq0_lat", 32'(lat_cyc), 32'd3);
    chk("beq0_pcw", 32'(pcw_cyc), 32'd1);

    run(7'b1101111, 5, 0, 0, 1'b1);
    chk("jal_lat", 32'(lat_cyc), 32'd4);
    run(7'b0010011, 3, 0, 0, 1'b1);
    chk("i_lat", 32'(lat_cyc), 32'd4);
    run(7'b0110011, 2, 2, 0, 1'b0);
    chk("r_wait_lat", 32'(lat_cyc), 32'd6);

`ifndef RV_ILLEGAL_TRAP_EN
    run(7'b1111111, 6, 0, 0, 1'b0);
    chk("nop_lat", 32'(lat_cyc), 32'd2);
`endif

    for (int i = 0; i < 16; i++) begin
      run(7'b0110011, 2, 0, 0, 1'(i));
      chk("r_rw", 32'(rw_cyc), 32'd1);
      if (i == 6 + 1 - NNOP) begin
        step(0, 7'b0110011, 1'b0, 1'b0);
        chk("wrap_15", 32'(instret), 32'd15);
      end
      if (i == 7 + 1 - NNOP) begin
        step(0, 7'b0110011, 1'b0, 1'b0);
        chk("wrap_0", 32'(instret), 32'd0);
      end
    end

    step(0, 7'b0000011, 1'b1, 1'b0);
    step(1, 7'b0000011, 1'b1, 1'b0);
    step(2, 7'b0000011, 1'b1, 1'b0);
    step(3, 7'b0000011, 1'b0, 1'b0);
    step(3, 7'b0000011, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_instret", 32'(instret), 32'd0);
    chk("midrst_reg_write", 32'(reg_write), 32'd0);
    chk("midrst_ir_write", 32'(ir_write), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_reg_write2", 32'(reg_write), 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;
    cnt_m = 0;
    run(7'b0000011, 0, 0, 1, 1'b0);
    chk("post_rst_lat", 32'(lat_cyc), 32'd6);
    step(0, 7'b0000011, 1'b0, 1'b0);
    chk("post_rst_instret", 32'(instret), 32'd1);

`ifdef RV_ILLEGAL_TRAP_EN
    step(0, 7'b1111111, 1'b1, 1'b0);
    step(1, 7'b1111111, 1'b1, 1'b0);
    ill_m = 1'b1;
    repeat (20) step(11, 7'b1111111, rnd(), rnd());
    chk("trap_ill", 32'(illegal_instr), 32'd1);
    chk("trap_instret", 32'(instret), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
